// File: rtl/adc_ser_multi_pkg.sv
// Shared definitions for the multi-channel ADC serial-link emulator:
// test-pattern mode encodings and a counter-width helper.
package adc_ser_multi_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_FIXED   = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    // Bits needed to hold a frame position 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_ser_lane.sv
// One serial lane: a DATA_WIDTH shift register that loads a word once per
// frame and shifts it out MSB- or LSB-first. The direction is captured with
// the word so a mid-frame change of LSB_FIRST only affects the next frame.
module adc_ser_lane #(
    parameter int DATA_WIDTH = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD,
    input  logic                  LSB_FIRST,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic                  DATA_OUT
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_lsb_first;

    // Load word and direction on LOAD, otherwise shift toward the output bit, filling with zeros.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift     <= '0;
            r_lsb_first <= 1'b0;
        end else if (LOAD) begin
            r_shift     <= DATA_IN;
            r_lsb_first <= LSB_FIRST;
        end else if (r_lsb_first) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
        end else begin
            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign DATA_OUT = r_lsb_first ? r_shift[0] : r_shift[DATA_WIDTH-1];

endmodule

// File: rtl/adc_ser_multi.sv
// Multi-channel ADC serial-link emulator. Runs on the ADC bit clock,
// aligns a frame counter to the rising edge of ENC, produces the frame clock,
// loads each lane once per frame (live data or a test pattern) and flags
// loss of frame alignment.
module adc_ser_multi
    import adc_ser_multi_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DATA_WIDTH  = 14,
    parameter int FRAME_LEN   = 16,
    parameter int LOAD_OFFSET = 5,
    parameter int SYNC_DLY    = 0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           ENC,
    input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
    input  logic [1:0]                     MODE,
    input  logic                           LSB_FIRST,
    input  logic [DATA_WIDTH-1:0]          PATTERN,
    output logic [CHANNELS-1:0]            DATA_OUT,
    output logic                           FCO,
    output logic                           LOCKED,
    output logic                           SYNC_ERR,
    output logic [15:0]                    SAMPLE_CNT
);

    localparam int CW = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] C_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] C_LOAD = CW'(LOAD_OFFSET);
    localparam logic [CW-1:0] C_SYNC = CW'(SYNC_DLY);
    localparam logic [CW-1:0] C_HALF = CW'(FRAME_LEN / 2);

    // Checkerboard word whose MSB is 0: 0101... read from the MSB.
    function automatic logic [DATA_WIDTH-1:0] checker_word();
        logic [DATA_WIDTH-1:0] w;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w[i] = ((DATA_WIDTH - 1 - i) % 2) == 1;
        end
        return w;
    endfunction

    localparam logic [DATA_WIDTH-1:0] C_CHK_A = checker_word();

    logic [1:0]            r_sync;
    logic [CW-1:0]         r_cnt;
    logic                  r_locked;
    logic                  r_sync_err;
    logic [DATA_WIDTH-1:0] r_ramp;
    logic                  r_chk_phase;
    logic [15:0]           r_sample_cnt;

    logic                                 w_rise;
    logic                                 w_load;
    logic [CW-1:0]                        w_cnt_inc;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0]  w_word;

    assign w_rise    = r_sync[0] & ~r_sync[1];
    assign w_cnt_inc = (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
    assign w_load    = r_locked & (r_cnt == C_LOAD);

    // Synchronise ENC, run the frame counter, and track lock and misalignment.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], ENC};
            if (w_rise) begin
                r_cnt    <= C_SYNC;
                r_locked <= 1'b1;
                // An edge that does not land where the free-running count expects it is a slip.
                if (r_locked && (w_cnt_inc != C_SYNC)) begin
                    r_sync_err <= 1'b1;
                end
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Per-load bookkeeping: ramp base, checkerboard phase and load counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ramp       <= '0;
            r_chk_phase  <= 1'b0;
            r_sample_cnt <= '0;
        end else if (w_load) begin
            r_ramp       <= r_ramp + DATA_WIDTH'(1);
            r_chk_phase  <= ~r_chk_phase;
            r_sample_cnt <= r_sample_cnt + 16'd1;
        end
    end

    // Select the word each lane loads according to the current mode.
    always_comb begin
        w_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode_e'(MODE))
                MODE_NORMAL: w_word[c] = DATA_IN[c*DATA_WIDTH +: DATA_WIDTH];
                MODE_RAMP:   w_word[c] = r_ramp + DATA_WIDTH'(c);
                MODE_FIXED:  w_word[c] = PATTERN;
                default:     w_word[c] = r_chk_phase ? ~C_CHK_A : C_CHK_A;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        adc_ser_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .CLK       (CLK),
            .RST       (RST),
            .LOAD      (w_load),
            .LSB_FIRST (LSB_FIRST),
            .DATA_IN   (w_word[c]),
            .DATA_OUT  (DATA_OUT[c])
        );
    end

    assign FCO        = (r_cnt >= C_HALF);
    assign LOCKED     = r_locked;
    assign SYNC_ERR   = r_sync_err;
    assign SAMPLE_CNT = r_sample_cnt;

endmodule

// File: tb/tb_adc_ser_multi.sv
// Testbench for adc_ser_multi at default parameters. Stimulus drives one ENC
// period per frame and pushes the words it expects into a scoreboard; a
// monitor deserialises the lanes after every load and compares.
module tb_adc_ser_multi;

    localparam int CH = 4;
    localparam int DW = 14;
    localparam int FL = 16;
    localparam int LOFS = 5;

    logic              CLK;
    logic              RST;
    logic              ENC;
    logic [CH*DW-1:0]  DATA_IN;
    logic [1:0]        MODE;
    logic              LSB_FIRST;
    logic [DW-1:0]     PATTERN;
    logic [CH-1:0]     DATA_OUT;
    logic              FCO;
    logic              LOCKED;
    logic              SYNC_ERR;
    logic [15:0]       SAMPLE_CNT;

    adc_ser_multi dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENC        (ENC),
        .DATA_IN    (DATA_IN),
        .MODE       (MODE),
        .LSB_FIRST  (LSB_FIRST),
        .PATTERN    (PATTERN),
        .DATA_OUT   (DATA_OUT),
        .FCO        (FCO),
        .LOCKED     (LOCKED),
        .SYNC_ERR   (SYNC_ERR),
        .SAMPLE_CNT (SAMPLE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [CH-1:0][DW-1:0] w;
        logic                  lsb;
        logic [15:0]           cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   loads   = 0;
    bit   busy    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference word for channel c, given the inputs at load time and the number of prior loads.
    function automatic logic [DW-1:0] model_word(input int c, input logic [1:0] mode,
                                                 input logic [CH*DW-1:0] din,
                                                 input logic [DW-1:0] pat, input int nload);
        case (mode)
            2'd0:    return din[c*DW +: DW];
            2'd1:    return DW'((nload + c) % (1 << DW));
            2'd2:    return pat;
            default: return ((nload % 2) == 0) ? 14'h1555 : 14'h2AAA;
        endcase
    endfunction

    // Serial stream of one frame: DW data bits in the chosen order, then zeros.
    function automatic logic [FL-1:0] serial_of(input logic [DW-1:0] w, input logic lsb);
        logic [FL-1:0] v;
        v = '0;
        for (int i = 0; i < DW; i++) v[i] = lsb ? w[i] : w[DW-1-i];
        return v;
    endfunction

    // One ENC period starting with a rising edge; optionally checks lock timing or resets mid-frame.
    task automatic run_frame(input int period, input logic [1:0] mode, input logic lsb,
                             input logic [DW-1:0] pat, input logic [DW-1:0] d0,
                             input bit chk, input int rst_at);
        exp_t e;
        int   lat;
        lat = -1;
        MODE      = mode;
        LSB_FIRST = lsb;
        PATTERN   = pat;
        for (int c = 0; c < CH; c++) DATA_IN[c*DW +: DW] = DW'($urandom);
        DATA_IN[DW-1:0] = d0;
        for (int c = 0; c < CH; c++) e.w[c] = model_word(c, mode, DATA_IN, pat, loads);
        e.lsb = lsb;
        loads++;
        e.cnt = 16'(loads);
        sb.push_back(e);
        ENC = 1'b1;
        for (int i = 1; i <= period; i++) begin
            @(posedge CLK); #1;
            if (rst_at == i) begin
                RST = 1'b1;
                ENC = 1'b0;
                break;
            end
            if (i == period / 2) ENC = 1'b0;
            if (i == 9) begin
                MODE      = 2'($urandom);
                LSB_FIRST = 1'($urandom);
                PATTERN   = DW'($urandom);
                for (int c = 0; c < CH; c++) DATA_IN[c*DW +: DW] = DW'($urandom);
            end
            if (chk) begin
                if (i == 1) check("locked_before_rise", 32'(LOCKED), 32'd0);
                if (i == 2) check("locked_after_rise", 32'(LOCKED), 32'd1);
                if (lat < 0 && SAMPLE_CNT != 16'd0) lat = i - 1;
            end
        end
        if (chk) check("first_load_edge_after_enc", 32'(lat), 32'd7);
    endtask

    // Monitor: each SAMPLE_CNT step marks a load; capture the following frame and compare.
    initial begin : monitor
        logic [15:0]   last;
        exp_t          e;
        logic [FL-1:0] got [CH];
        logic [FL-1:0] fco_got;
        logic [FL-1:0] fco_exp;
        bit            abort;
        last = '0;
        for (int i = 0; i < FL; i++) fco_exp[i] = ((i + LOFS + 1) % FL) >= (FL / 2);
        forever begin
            @(negedge CLK);
            if (RST) begin
                last = '0;
                continue;
            end
            if (SAMPLE_CNT != last) begin
                last = SAMPLE_CNT;
                if (sb.size() == 0) begin
                    check("unexpected_load", 32'(SAMPLE_CNT), 32'hFFFF_FFFF);
                    continue;
                end
                e = sb.pop_front();
                check("sample_cnt", 32'(SAMPLE_CNT), 32'(e.cnt));
                busy  = 1;
                abort = 0;
                for (int i = 0; i < FL; i++) begin
                    if (i > 0) @(negedge CLK);
                    if (RST) begin
                        abort = 1;
                        last  = '0;
                        break;
                    end
                    for (int c = 0; c < CH; c++) got[c][i] = DATA_OUT[c];
                    fco_got[i] = FCO;
                end
                busy = 0;
                if (!abort) begin
                    for (int c = 0; c < CH; c++)
                        check($sformatf("lane%0d_frame%0d", c, e.cnt), 32'(got[c]),
                              32'(serial_of(e.w[c], e.lsb)));
                    check($sformatf("fco_frame%0d", e.cnt), 32'(fco_got), 32'(fco_exp));
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit quiet;
        RST = 1'b1; ENC = 1'b0; MODE = '0; LSB_FIRST = 1'b0; PATTERN = '0; DATA_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_data_out", 32'(DATA_OUT), 32'd0);
        check("reset_fco", 32'(FCO), 32'd0);
        check("reset_locked", 32'(LOCKED), 32'd0);
        check("reset_sync_err", 32'(SYNC_ERR), 32'd0);
        check("reset_sample_cnt", 32'(SAMPLE_CNT), 32'd0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Normal mode, MSB first then LSB first.
        run_frame(16, 2'd0, 1'b0, '0, 14'h2AAA, 1, 0);
        for (int n = 0; n < 3; n++) run_frame(16, 2'd0, 1'b0, '0, DW'($urandom), 0, 0);
        run_frame(16, 2'd0, 1'b1, '0, 14'h2AAA, 0, 0);
        for (int n = 0; n < 3; n++) run_frame(16, 2'd0, 1'b1, '0, DW'($urandom), 0, 0);
        // Ramp, fixed pattern, checkerboard.
        for (int n = 0; n < 3; n++) run_frame(16, 2'd1, 1'($urandom), '0, DW'($urandom), 0, 0);
        run_frame(16, 2'd2, 1'b0, 14'h1234, DW'($urandom), 0, 0);
        run_frame(16, 2'd2, 1'b1, 14'h1234, DW'($urandom), 0, 0);
        run_frame(16, 2'd2, 1'b0, DW'($urandom), DW'($urandom), 0, 0);
        for (int n = 0; n < 3; n++) run_frame(16, 2'd3, 1'($urandom), '0, DW'($urandom), 0, 0);
        // Random mix.
        for (int n = 0; n < 8; n++)
            run_frame(16, 2'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), 0, 0);
        check("sync_err_while_aligned", 32'(SYNC_ERR), 32'd0);

        // Delay the next ENC edge by 3 clocks.
        run_frame(19, 2'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), 0, 0);
        run_frame(16, 2'd0, 1'b0, '0, DW'($urandom), 0, 0);
        check("sync_err_after_slip", 32'(SYNC_ERR), 32'd1);
        for (int n = 0; n < 3; n++)
            run_frame(16, 2'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), 0, 0);
        check("sync_err_sticky", 32'(SYNC_ERR), 32'd1);

        // Reset while the frame counter reads 9.
        run_frame(16, 2'd0, 1'b0, '0, DW'($urandom), 0, 11);
        @(posedge CLK); #1;
        check("midrst_data_out", 32'(DATA_OUT), 32'd0);
        check("midrst_fco", 32'(FCO), 32'd0);
        check("midrst_locked", 32'(LOCKED), 32'd0);
        check("midrst_sync_err", 32'(SYNC_ERR), 32'd0);
        check("midrst_sample_cnt", 32'(SAMPLE_CNT), 32'd0);
        sb.delete();
        loads = 0;
        RST = 1'b0;
        quiet = 1;
        for (int n = 0; n < 40; n++) begin
            @(posedge CLK); #1;
            if (SAMPLE_CNT != 16'd0 || DATA_OUT != '0 || LOCKED != 1'b0) quiet = 0;
        end
        check("no_load_without_enc", 32'(quiet), 32'd1);

        // Relock and restart the ramp from zero.
        run_frame(16, 2'd1, 1'b0, '0, DW'($urandom), 1, 0);
        for (int n = 0; n < 3; n++) run_frame(16, 2'd1, 1'b0, '0, DW'($urandom), 0, 0);
        check("sync_err_after_relock", 32'(SYNC_ERR), 32'd0);

        // Let the last frame finish shifting before the free-running counter reloads.
        repeat (7) @(posedge CLK);
        @(negedge CLK); #1;
        check("scoreboard_drained", 32'(sb.size()) + 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
